// File: rtl/logic_pkg.sv
// Shared definitions for the logic-unit issuer: opcodes, FSM encoding and command layout.
package logic_pkg;

  localparam logic [2:0] OP_AND     = 3'd0;
  localparam logic [2:0] OP_OR      = 3'd1;
  localparam logic [2:0] OP_NOR     = 3'd2;
  localparam logic [2:0] OP_XOR     = 3'd3;
  localparam logic [2:0] OP_XNOR    = 3'd4;
  localparam logic [2:0] OP_NOTA    = 3'd5;
  localparam logic [2:0] OP_NOTB    = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDrive = 2'd1;
  localparam logic [1:0] StResp  = 2'd2;

  localparam int unsigned CmdDataW = 32;
  localparam int unsigned CmdTagW  = 4;

  // Default-width command layout; the issuer packs FIFO entries in this field order.
  typedef struct packed {
    logic [2:0]          op;
    logic [CmdDataW-1:0] a;
    logic [CmdDataW-1:0] b;
    logic [CmdTagW-1:0]  tag;
  } cmd_t;

endpackage

// File: rtl/logic_cmd_fifo.sv
// Synchronous FIFO for issuer commands; synchronous active-high reset empties it.
module logic_cmd_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push_i && !pop_i)      count_q <= count_q + CntW'(1);
      else if (pop_i && !push_i) count_q <= count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/logic_op_issuer.sv
// Issues queued logic commands to the combinational logic unit and returns tagged results.
// Define LOGIC_OP_ISSUER_PARITY_EN to add the rsp_parity output.
module logic_op_issuer
  import logic_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [2:0]        sel2,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err,
`ifdef LOGIC_OP_ISSUER_PARITY_EN
  output logic              rsp_parity,
`endif
  output logic              busy
);

  localparam int unsigned EntryW = 3 + 2 * DATA_W + TAG_W;

  logic [EntryW-1:0] wdata, head;
  logic              full, empty, push, pop;
  logic [2:0]        head_op;
  logic [DATA_W-1:0] head_a, head_b;
  logic [TAG_W-1:0]  head_tag;

  logic [1:0]        state_q, state_d;
  logic [2:0]        sel2_q, sel2_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0]  tag_q, tag_d, rsp_tag_q, rsp_tag_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
`ifdef LOGIC_OP_ISSUER_PARITY_EN
  logic              rsp_parity_q, rsp_parity_d;
`endif

  assign wdata    = {cmd_op, cmd_a, cmd_b, cmd_tag};
  assign head_op  = head[EntryW-1 -: 3];
  assign head_a   = head[TAG_W+DATA_W +: DATA_W];
  assign head_b   = head[TAG_W +: DATA_W];
  assign head_tag = head[TAG_W-1:0];

  // Ready looks only at the registered full flag, never at a same-cycle pop.
  assign push = cmd_valid && !full;

  logic_cmd_fifo #(
    .Width(EntryW),
    .Depth(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .wdata_i(wdata),
    .pop_i  (pop),
    .rdata_o(head),
    .full_o (full),
    .empty_o(empty)
  );

  always_comb begin
    state_d     = state_q;
    sel2_d      = sel2_q;
    a_d         = a_q;
    b_d         = b_q;
    tag_d       = tag_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_err_d   = rsp_err_q;
`ifdef LOGIC_OP_ISSUER_PARITY_EN
    rsp_parity_d = rsp_parity_q;
`endif
    pop = 1'b0;

    if (state_q == StDrive) begin
      rsp_data_d  = result;
      rsp_tag_d   = tag_q;
      rsp_err_d   = 1'b0;
      rsp_valid_d = 1'b1;
`ifdef LOGIC_OP_ISSUER_PARITY_EN
      rsp_parity_d = ^result;
`endif
      state_d = StResp;
    end else if (state_q == StIdle || (state_q == StResp && rsp_ready)) begin
      rsp_valid_d = 1'b0;
      state_d     = StIdle;
      // A consumed response may be followed by the next issue in the same cycle.
      if (!empty) begin
        pop = 1'b1;
        if (head_op == OP_ILLEGAL) begin
          rsp_data_d  = '0;
          rsp_tag_d   = head_tag;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
`ifdef LOGIC_OP_ISSUER_PARITY_EN
          rsp_parity_d = 1'b0;
`endif
          state_d = StResp;
        end else begin
          sel2_d  = head_op;
          a_d     = head_a;
          b_d     = head_b;
          tag_d   = head_tag;
          state_d = StDrive;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sel2_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
`ifdef LOGIC_OP_ISSUER_PARITY_EN
      rsp_parity_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sel2_q      <= sel2_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_err_q   <= rsp_err_d;
`ifdef LOGIC_OP_ISSUER_PARITY_EN
      rsp_parity_q <= rsp_parity_d;
`endif
    end
  end

  assign cmd_ready = !full;
  assign sel2      = sel2_q;
  assign a         = a_q;
  assign b         = b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_err   = rsp_err_q;
`ifdef LOGIC_OP_ISSUER_PARITY_EN
  assign rsp_parity = rsp_parity_q;
`endif
  assign busy = !empty || (state_q != StIdle);

endmodule

// File: tb/tb_logic_op_issuer.sv
// Bench for logic_op_issuer: directed cases plus randomized traffic against a queue model.
module tb_logic_op_issuer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [31:0] cmd_a = '0, cmd_b = '0;
  logic [3:0]  cmd_tag = '0;
  logic [2:0]  sel2;
  logic [31:0] a, b, result;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  logic        busy;
`ifdef LOGIC_OP_ISSUER_PARITY_EN
  logic        rsp_parity;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  logic_op_issuer dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_a    (cmd_a),
    .cmd_b    (cmd_b),
    .cmd_tag  (cmd_tag),
    .sel2     (sel2),
    .a        (a),
    .b        (b),
    .result   (result),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_tag  (rsp_tag),
    .rsp_err  (rsp_err),
`ifdef LOGIC_OP_ISSUER_PARITY_EN
    .rsp_parity(rsp_parity),
`endif
    .busy     (busy)
  );

  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] x,
                                         input logic [31:0] y);
    case (op)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return ~(x | y);
      3'd3:    return x ^ y;
      3'd4:    return ~(x ^ y);
      3'd5:    return ~x;
      3'd6:    return ~y;
      default: return 32'h0;
    endcase
  endfunction

  // Behavioural logic unit the issuer drives.
  always_comb result = ref_op(sel2, a, b);

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called just after an edge; returns just after the edge that accepted the command.
  task automatic push_cmd(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                          input logic [3:0] tg);
    bit ok = 1'b0;
    cmd_op = op; cmd_a = av; cmd_b = bv; cmd_tag = tg; cmd_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check_val("push_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic collect_rsp(input string nm, input logic [3:0] tg, input logic [31:0] dat,
                             input logic er, input logic par);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check_val({nm, "_timeout"}, 64'd0, 64'd1);
    else begin
      check_val({nm, "_tag"}, rsp_tag, tg);
      check_val({nm, "_data"}, rsp_data, dat);
      check_val({nm, "_err"}, rsp_err, er);
`ifdef LOGIC_OP_ISSUER_PARITY_EN
      check_val({nm, "_par"}, rsp_parity, par);
`else
      if (par) begin end
`endif
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string nm);
    check_val({nm, "_cmd_ready"}, cmd_ready, 1);
    check_val({nm, "_sel2"}, sel2, 0);
    check_val({nm, "_a"}, a, 0);
    check_val({nm, "_b"}, b, 0);
    check_val({nm, "_rsp_valid"}, rsp_valid, 0);
    check_val({nm, "_rsp_data"}, rsp_data, 0);
    check_val({nm, "_rsp_tag"}, rsp_tag, 0);
    check_val({nm, "_rsp_err"}, rsp_err, 0);
    check_val({nm, "_busy"}, busy, 0);
`ifdef LOGIC_OP_ISSUER_PARITY_EN
    check_val({nm, "_par"}, rsp_parity, 0);
`endif
  endtask

  // Sampled at the negedge: handshakes seen here take effect at the next posedge.
  task automatic sb_step();
    exp_t e;
    if (rsp_valid) begin
      if (exp_q.size() == 0) check_val("sb_unexpected_rsp", 64'd1, 64'd0);
      else begin
        e = exp_q[0];
        check_val("sb_tag", rsp_tag, e.tag);
        check_val("sb_data", rsp_data, e.data);
        check_val("sb_err", rsp_err, e.err);
`ifdef LOGIC_OP_ISSUER_PARITY_EN
        check_val("sb_par", rsp_parity, e.err ? 1'b0 : ^e.data);
`endif
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
    if (cmd_valid && cmd_ready) begin
      e.tag  = cmd_tag;
      e.err  = (cmd_op == 3'd7);
      e.data = e.err ? 32'h0 : ref_op(cmd_op, cmd_a, cmd_b);
      exp_q.push_back(e);
    end
  endtask

  initial begin
    bit seen;
    bit acc;
    logic [31:0] xa, xb, na, nb, ta;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_vals("reset");

    // Single AND: command driven after edge E0, pushed at E1, response after E3.
    rsp_ready = 1'b1;
    push_cmd(3'd0, 32'hF0F0_00FF, 32'h0FF0_FF0F, 4'd3);
    check_val("and_valid_e1", rsp_valid, 0);
    check_val("and_busy_e1", busy, 1);
    @(posedge clk); #1;
    check_val("and_valid_e2", rsp_valid, 0);
    check_val("and_sel2", sel2, 0);
    check_val("and_a", a, 32'hF0F0_00FF);
    check_val("and_b", b, 32'h0FF0_FF0F);
    @(posedge clk); #1;
    check_val("and_valid_e3", rsp_valid, 1);
    check_val("and_data", rsp_data, 32'h00F0_000F);
    check_val("and_tag", rsp_tag, 3);
    check_val("and_err", rsp_err, 0);
    @(posedge clk); #1;
    check_val("and_valid_after", rsp_valid, 0);
    check_val("and_busy_after", busy, 0);

    // Illegal op: response after E2, operands to the unit untouched.
    push_cmd(3'd7, 32'h1111_1111, 32'h2222_2222, 4'd9);
    check_val("ill_valid_e1", rsp_valid, 0);
    @(posedge clk); #1;
    check_val("ill_valid_e2", rsp_valid, 1);
    check_val("ill_err", rsp_err, 1);
    check_val("ill_data", rsp_data, 0);
    check_val("ill_tag", rsp_tag, 9);
    check_val("ill_sel2", sel2, 0);
    check_val("ill_a", a, 32'hF0F0_00FF);
    check_val("ill_b", b, 32'h0FF0_FF0F);
`ifdef LOGIC_OP_ISSUER_PARITY_EN
    check_val("ill_par", rsp_parity, 0);
`endif
    @(posedge clk); #1;

    // Backpressure: fill the FIFO behind a stalled response.
    rsp_ready = 1'b0;
    xa = 32'hDEAD_BEEF; xb = 32'h1234_5678;
    na = 32'hF000_000F; nb = 32'h0F00_00F0;
    ta = 32'h5555_AAAA;
    push_cmd(3'd3, xa, xb, 4'd1);
    push_cmd(3'd2, na, nb, 4'd2);
    push_cmd(3'd5, ta, 32'h0, 4'd3);
    repeat (3) begin
      @(negedge clk);
      check_val("bp_cmd_ready", cmd_ready, 0);
      check_val("bp_hold_valid", rsp_valid, 1);
      check_val("bp_hold_tag", rsp_tag, 1);
      check_val("bp_hold_data", rsp_data, xa ^ xb);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    collect_rsp("bp_xor", 4'd1, xa ^ xb, 1'b0, ^(xa ^ xb));
    collect_rsp("bp_nor", 4'd2, ~(na | nb), 1'b0, ^(~(na | nb)));
    collect_rsp("bp_nota", 4'd3, ~ta, 1'b0, ^(~ta));

    // Reset while in DRIVE with a second command queued.
    push_cmd(3'd0, 32'hFFFF_0000, 32'hFF00_FF00, 4'd5);
    cmd_op = 3'd1; cmd_a = 32'h0000_00F0; cmd_b = 32'h0000_000F; cmd_tag = 4'd6;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check_val("rst_mid_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_vals("rst_mid");
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid || busy) seen = 1'b1;
    end
    check_val("rst_no_rsp", seen, 0);
    @(posedge clk); #1;

`ifdef LOGIC_OP_ISSUER_PARITY_EN
    push_cmd(3'd1, 32'h1, 32'h2, 4'd4);
    collect_rsp("par_or", 4'd4, 32'h3, 1'b0, 1'b0);
    push_cmd(3'd6, 32'h0, 32'hFFFF_FFFE, 4'd7);
    collect_rsp("par_notb", 4'd7, 32'h1, 1'b0, 1'b1);
`endif

    // Randomized traffic with random backpressure.
    acc = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (!cmd_valid || acc) begin
        acc = 1'b0;
        if ($urandom_range(0, 99) < 60) begin
          cmd_valid = 1'b1;
          cmd_op    = 3'($urandom_range(0, 7));
          cmd_a     = $urandom;
          cmd_b     = $urandom;
          cmd_tag   = 4'($urandom_range(0, 15));
        end else begin
          cmd_valid = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 99) < 65);
      @(negedge clk);
      sb_step();
      if (cmd_valid && cmd_ready) acc = 1'b1;
    end
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      sb_step();
      if (exp_q.size() == 0 && !rsp_valid) break;
    end
    check_val("drain_left", exp_q.size(), 0);
    check_val("drain_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
